// File: rtl/alsu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALSU controller.
package alsu_seq_pkg;

    localparam logic [1:0] OPC_ARITH = 2'b00;
    localparam logic [1:0] OPC_LOGIC = 2'b01;
    localparam logic [1:0] OPC_SHR   = 2'b10;
    localparam logic [1:0] OPC_SHL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/alsu_seq_alsu.sv
// 4-bit arithmetic-logic-shift unit; purely combinational, shifts zero-filled.
module alsu_seq_alsu
    import alsu_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] sel,
    input  logic       cin,
    output logic [3:0] f,
    output logic       cout
);

    logic [3:0] y;

    always_comb begin
        y    = '0;
        f    = '0;
        cout = 1'b0;
        case (sel[3:2])
            OPC_ARITH: begin
                case (sel[1:0])
                    2'b00:   y = a;
                    2'b01:   y = ~a;
                    2'b10:   y = '0;
                    default: y = '1;
                endcase
                {cout, f} = {1'b0, b} + {1'b0, y} + {4'b0, cin};
            end
            OPC_LOGIC: begin
                case (sel[1:0])
                    2'b00:   f = a & b;
                    2'b01:   f = a | b;
                    2'b10:   f = a ^ b;
                    default: f = ~b;
                endcase
            end
            OPC_SHR: begin
                f    = {1'b0, a[3:1]};
                cout = a[0];
            end
            default: begin
                f    = {a[2:0], 1'b0};
                cout = a[3];
            end
        endcase
    end

endmodule

// File: rtl/alsu_seq.sv
// Nibble-serial controller around a shared 4-bit ALSU with valid/ready in and out.
// Optional zero flag enabled by defining ALSU_SEQ_FLAGS_EN.
module alsu_seq
    import alsu_seq_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero
);

    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    state_t           state, state_next;
    logic [KW-1:0]    k;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, result_q, result_next;
    logic             carry_q, carry_done;
    logic [KW+1:0]    sh;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH:0]   a_hi_sh, a_lo_sh;
    logic [3:0]       alu_f, nib_out;
    logic             alu_cin, alu_cout, last;
    logic [1:0]       opc;

    assign opc = op_q[3:2];
    assign sh  = {k, 2'b00};
    assign last = (k == K_LAST);

    // Neighbour bits for shift patching: a 0 guard bit on each end makes the
    // top nibble (SHR) and nibble 0 (SHL) zero-fill without special cases.
    always_comb begin
        a_sh    = a_q >> sh;
        b_sh    = b_q >> sh;
        a_hi_sh = {1'b0, a_q} >> sh;
        a_lo_sh = {a_q, 1'b0} >> sh;
        alu_cin = (opc == OPC_ARITH) ? carry_q : 1'b0;
    end

    alsu_seq_alsu u_alsu (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .sel  (op_q),
        .cin  (alu_cin),
        .f    (alu_f),
        .cout (alu_cout)
    );

    always_comb begin
        nib_out = alu_f;
        if (opc == OPC_SHR) nib_out[3] = a_hi_sh[4];
        if (opc == OPC_SHL) nib_out[0] = a_lo_sh[0];
        result_next = result_q;
        result_next[sh +: 4] = nib_out;
        case (opc)
            OPC_ARITH: carry_done = alu_cout;
            OPC_LOGIC: carry_done = 1'b0;
            OPC_SHR:   carry_done = a_q[0];
            default:   carry_done = a_q[WIDTH-1];
        endcase
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            out_carry <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (in_valid) begin
                    op_q      <= in_op;
                    a_q       <= in_a;
                    b_q       <= in_b;
                    k         <= '0;
                    result_q  <= '0;
                    carry_q   <= in_cin;
                    out_carry <= 1'b0;
                end
                RUN: begin
                    result_q <= result_next;
                    carry_q  <= alu_cout;
                    k        <= last ? '0 : k + 1'b1;
                    if (last) out_carry <= carry_done;
                end
                default: ;
            endcase
        end
    end

    assign out_result = result_q;

`ifdef ALSU_SEQ_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            out_zero <= 1'b0;
        end else if (state == RUN && last) begin
            out_zero <= (result_next == '0);
        end
    end
`else
    assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alsu_seq.sv
// Randomised and directed bench for alsu_seq against a whole-word reference model.
module tb_alsu_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_cin;
    logic [3:0]   in_op;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready, out_carry, out_zero;
    logic [W-1:0] out_result;

    int total = 0;
    int bad   = 0;

    alsu_seq #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_cin     (in_cin),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic, returns {carry, result}.
    function automatic logic [W:0] model(input logic [3:0] op, input logic cin,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] y;
        if (op[3]) begin
            if (op[2]) return {a[W-1], a << 1};
            else       return {a[0], a >> 1};
        end
        if (op[2]) begin
            case (op[1:0])
                2'b00:   return {1'b0, a & b};
                2'b01:   return {1'b0, a | b};
                2'b10:   return {1'b0, a ^ b};
                default: return {1'b0, ~b};
            endcase
        end
        case (op[1:0])
            2'b00:   y = a;
            2'b01:   y = ~a;
            2'b10:   y = '0;
            default: y = '1;
        endcase
        return {1'b0, b} + {1'b0, y} + (W+1)'(cin);
    endfunction

    function automatic logic exp_zero(input logic [W-1:0] r);
`ifdef ALSU_SEQ_FLAGS_EN
        return (r == '0);
`else
        return 1'b0;
`endif
    endfunction

    // Present a command and return just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic cin, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_cin = cin; in_a = a; in_b = b;
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 4'($urandom); in_cin = 1'($urandom); in_a = W'($urandom); in_b = W'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 0);
        check("idle_ready", 32'(in_ready), 1);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic cin, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int hold,
                           output logic [W-1:0] res, output logic c);
        logic [W:0] e;
        int lat;
        e = model(op, cin, a, b);
        send(op, cin, a, b);
        wait_done(lat);
        check("latency", 32'(lat), NIB);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 1);
            check("hold_ready", 32'(in_ready), 0);
            check("hold_result", 32'(out_result), 32'(e[W-1:0]));
        end
        check("result", 32'(out_result), 32'(e[W-1:0]));
        check("carry", 32'(out_carry), 32'(e[W]));
        check("zero", 32'(out_zero), 32'(exp_zero(e[W-1:0])));
        res = out_result;
        c   = out_carry;
        consume();
    endtask

    initial begin
        logic [W-1:0] r;
        logic         c;
        logic [W:0]   e;
        logic         seen;
        int           lat;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_cin = 1'b0; in_a = '0; in_b = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_result", 32'(out_result), 0);
        check("rst_carry", 32'(out_carry), 0);
        check("rst_zero", 32'(out_zero), 0);
        @(negedge clk); rst_n = 1'b1;

        run_cmd(4'b0000, 1'b0, 16'h00FF, 16'h0001, 0, r, c);
        check("add_const", 32'(r), 32'h0100);
        run_cmd(4'b0001, 1'b1, 16'h0001, 16'h0000, 1, r, c);
        check("sub_const", 32'(r), 32'hFFFF);
        run_cmd(4'b0000, 1'b0, 16'hFFFF, 16'h0001, 0, r, c);
        check("wrap_carry", 32'(c), 1);
        for (int i = 0; i < 4; i++)
            run_cmd(4'(4 + i), 1'b1, 16'h5A5A, 16'h0FF0, 0, r, c);
        run_cmd(4'b1000, 1'b0, 16'h8421, 16'h0000, 0, r, c);
        check("shr_const", 32'(r), 32'h4210);
        run_cmd(4'b1100, 1'b0, 16'h8421, 16'h0000, 0, r, c);
        check("shl_const", 32'(r), 32'h0842);

        // Backpressure with a pending command waiting behind the result.
        e = model(4'b0110, 1'b0, 16'h1234, 16'hFF00);
        send(4'b0000, 1'b1, 16'h1111, 16'h2222);
        wait_done(lat);
        check("bp_latency", 32'(lat), NIB);
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'b0110; in_cin = 1'b0; in_a = 16'h1234; in_b = 16'hFF00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 1);
            check("bp_ready", 32'(in_ready), 0);
            check("bp_result", 32'(out_result), 32'h3334);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check("bp_consumed", 32'(out_valid), 0);
        check("bp_not_taken", 32'(in_ready), 1);
        @(posedge clk); #1;
        check("bp_taken", 32'(in_ready), 0);
        in_valid = 1'b0;
        wait_done(lat);
        check("bp2_latency", 32'(lat), NIB);
        check("bp2_result", 32'(out_result), 32'(e[W-1:0]));
        consume();

        // Reset while nibble 2 is in flight.
        send(4'b0000, 1'b0, 16'h0F0F, 16'h0101);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_ready", 32'(in_ready), 1);
        check("mid_rst_result", 32'(out_result), 0);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("mid_rst_no_valid", 32'(seen), 0);
        check("post_rst_ready", 32'(in_ready), 1);
        run_cmd(4'b0001, 1'b1, 16'h0003, 16'h0010, 0, r, c);

        for (int i = 0; i < 40; i++)
            run_cmd(4'($urandom), 1'($urandom), W'($urandom), W'($urandom),
                    int'($urandom_range(0, 2)), r, c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alsu_seq.md
# alsu_seq

Multi-cycle controller that runs WIDTH-bit operations through a single shared 4-bit arithmetic-logic-shift unit, one nibble per clock, LSB nibble first. The controller accepts a command over a valid/ready handshake and drives the unit's four select lines and carry-in. It chains carries between nibbles, injects neighbour bits for shifts, and returns the assembled result with flags over a second valid/ready handshake. It sits between an instruction decoder (upstream) and the register-file write port (downstream).

## Interface
- NIBBLES, 4: nibbles per operation; WIDTH = 4*NIBBLES; legal range 1..8
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  command present
- in_ready  out  1  controller can accept; high only in IDLE
- in_op  in  4  {s3,s2,s1,s0} operation code, encoding below
- in_cin  in  1  carry into nibble 0 (arithmetic ops only)
- in_a, in_b  in  WIDTH  operands A, B
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  WIDTH  result
- out_carry  out  1  carry / shifted-out bit
- out_zero  out  1  result == 0 (see Configuration)

## Operation
- Op encoding, applied identically to every nibble:
  - 0000: B+A+cin
  - 0001: B+~A+cin (B−A when cin=1)
  - 0010: B+cin
  - 0011: B+all-ones+cin
  - 0100: A&B
  - 0101: A|B
  - 0110: A^B
  - 0111: ~B
  - 10xx: A>>1
  - 11xx: A<<1
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch op/cin/A/B, clear nibble index k and the result register, go to RUN.
  - RUN: drive nibble k of A and B into the unit; write the 4-bit output into result nibble k; k++. After k=NIBBLES-1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Arithmetic: nibble 0 cin = latched cin; nibble k>0 cin = unit carry registered from nibble k−1. out_carry = carry out of the top nibble.
- Logic: unit cin driven 0; out_carry = 0.
- Shifts (unit shifts are zero-filled within a nibble; the controller patches the nibble boundary):
  - SHR: nibble k bit3 = A[4k+4], or 0 for the top nibble; out_carry = A[0].
  - SHL: nibble k bit0 = A[4k−1], or 0 for nibble 0; out_carry = A[WIDTH−1].
  - The unit carry output is ignored for shifts.
- in_op, in_a, in_b and in_cin are ignored outside IDLE; the latched copies stay stable for the whole operation.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_carry=0, out_zero=0, k=0, internal carry=0.
- Latency: command accepted at edge T; out_valid rises after edge T+NIBBLES. One extra cycle before the next command can be accepted.
- out_result, out_carry and out_zero are registered and held stable while out_valid=1 and out_ready=0.
- in_ready=0 in RUN and DONE. A DONE handshake and a new in_valid in the same cycle: only the result is consumed; the command is taken in the following IDLE cycle.
- Reset asserted mid-RUN or mid-DONE: the operation is discarded immediately; no partial result is ever flagged valid.
- NIBBLES=1: RUN lasts one cycle. Shift injection degenerates to zero-fill.

## Configuration
- ALSU_SEQ_FLAGS_EN defined: out_zero is registered in DONE as (result == 0).
- ALSU_SEQ_FLAGS_EN undefined: out_zero is tied 0 and no zero-detect logic is generated. All other behaviour is identical.

## Structure
- Shared package alsu_seq_pkg:
  - op-class constants OPC_ARITH=2'b00, OPC_LOGIC=2'b01, OPC_SHR=2'b10, OPC_SHL=2'b11
  - FSM state enum {IDLE, RUN, DONE}
- One sub-module: a single instance of the existing 4-bit ALSU, driven combinationally from the nibble mux. No other hierarchy.

## Test plan
- ADD, op 0000, A=0x00FF, B=0x0001, cin=0 -> result 0x0100, carry 0; out_valid exactly 4 cycles after accept.
- Subtract, op 0001, cin=1, A=0x0001, B=0x0000 -> result 0xFFFF, carry 0. Then op 0000, A=0xFFFF, B=0x0001 -> result 0x0000, carry 1, zero 1 (with FLAGS_EN).
- Logic sweep, A=0x5A5A, B=0x0FF0:
  - AND -> 0x0A50
  - OR -> 0x5FFA
  - XOR -> 0x55AA
  - NOT B -> 0xF00F
  - carry 0 in every case
- Shifts, A=0x8421: SHR -> 0x4210, carry 1; SHL -> 0x0842, carry 1. Cross-nibble bit patching must be visible in both results.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> result stable, in_ready=0, a pending in_valid is not taken; it is accepted one cycle after out_ready.
- Reset pulse during RUN nibble 2 -> out_valid never rises for that command; in_ready=1 after release; the next command completes correctly.
